// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
// Signed operands are reduced to magnitudes up front; signs are reapplied in FIXUP.
module mult_div_unit #(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [N_BITS-1:0] rs_data_i,
  input  logic [N_BITS-1:0] rt_data_i,
  input  logic              mthi_i,
  input  logic              mtlo_i,
  input  logic [N_BITS-1:0] wr_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_BITS-1:0] hi_o,
  output logic [N_BITS-1:0] lo_o
);

  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state;
  logic [CW-1:0]       counter;
  logic                is_div;
  logic                res_neg;
  logic                rem_neg;
  logic [N_BITS-1:0]   opb;
  logic [2*N_BITS-1:0] acc;
  logic [N_BITS-1:0]   rem;

  logic                rs_neg, rt_neg;
  logic [N_BITS-1:0]   rs_mag, rt_mag;
  logic [N_BITS:0]     mul_sum;
  logic [N_BITS:0]     rem_shift, rem_diff;
  logic [2*N_BITS-1:0] prod_fix;
  logic [N_BITS-1:0]   quo_fix, rem_fix;

  // op_i[0] set means unsigned, op_i[1] set means divide
  assign rs_neg = !op_i[0] && rs_data_i[N_BITS-1];
  assign rt_neg = !op_i[0] && rt_data_i[N_BITS-1];
  assign rs_mag = rs_neg ? -rs_data_i : rs_data_i;
  assign rt_mag = rt_neg ? -rt_data_i : rt_data_i;

  assign mul_sum   = {1'b0, acc[2*N_BITS-1:N_BITS]} + (acc[0] ? {1'b0, opb} : '0);
  assign rem_shift = {rem, acc[N_BITS-1]};
  assign rem_diff  = rem_shift - {1'b0, opb};

  assign prod_fix = res_neg ? -acc : acc;
  assign quo_fix  = res_neg ? -acc[N_BITS-1:0] : acc[N_BITS-1:0];
  assign rem_fix  = rem_neg ? -rem : rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      opb     <= '0;
      acc     <= '0;
      rem     <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state   <= CALC;
            busy_o  <= 1'b1;
            counter <= '0;
            is_div  <= op_i[1];
            // Divide by zero keeps the all-ones quotient unsigned
            res_neg <= (rs_neg ^ rt_neg) && !(op_i[1] && rt_data_i == '0);
            rem_neg <= rs_neg;
            acc     <= {{N_BITS{1'b0}}, (op_i[1] ? rs_mag : rt_mag)};
            opb     <= op_i[1] ? rt_mag : rs_mag;
            rem     <= '0;
          end else begin
            state <= IDLE;
            if (mthi_i) hi_o <= wr_data_i;
            if (mtlo_i) lo_o <= wr_data_i;
          end
        end
        CALC: begin
          if (is_div) begin
            if (!rem_diff[N_BITS]) begin
              rem <= rem_diff[N_BITS-1:0];
              acc <= {acc[2*N_BITS-1:N_BITS], acc[N_BITS-2:0], 1'b1};
            end else begin
              rem <= rem_shift[N_BITS-1:0];
              acc <= {acc[2*N_BITS-1:N_BITS], acc[N_BITS-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[N_BITS-1:1]};
          end
          counter <= counter + 1'b1;
          if (counter == LAST) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            hi_o <= rem_fix;
            lo_o <= quo_fix;
          end else begin
            hi_o <= prod_fix[2*N_BITS-1:N_BITS];
            lo_o <= prod_fix[N_BITS-1:0];
          end
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
// Expected HI/LO come from plain 64-bit arithmetic on the operands.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_data_i, rt_data_i, wr_data_i;
  logic        mthi_i, mtlo_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.N_BITS(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wr_data_i(wr_data_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      default: begin
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Caller is at a negedge; start is seen on the following rising edge (E0)
  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; op_i = op; rs_data_i = a; rt_data_i = b;
    @(negedge clk);
    start_i = 1'b0;
    rs_data_i = $urandom; rt_data_i = $urandom;
  endtask

  task automatic wait_done(inout int edges);
    while (!done_o && edges < 100) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int edges;
    logic [63:0] exp;
    exp = model(op, a, b);
    drive_start(op, a, b);
    check({tag, ".busy"}, 64'(busy_o), 64'd1);
    edges = 0;
    wait_done(edges);
    check({tag, ".lat"}, 64'(edges), 64'd33);
    check({tag, ".hilo"}, {hi_o, lo_o}, exp);
    check({tag, ".busy_done"}, 64'(busy_o), 64'd0);
    @(negedge clk);
    check({tag, ".pulse"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int edges;
    logic [31:0] lo_before;
    logic [63:0] exp;
    bit saw_done;

    reset = 1'b1; start_i = 1'b0; op_i = 2'b00; rs_data_i = '0; rt_data_i = '0;
    mthi_i = 1'b0; mtlo_i = 1'b0; wr_data_i = '0;
    repeat (3) @(negedge clk);
    check("rst.state", {30'b0, busy_o, done_o, hi_o, lo_o}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu",      2'b11, 32'd7, 32'd2);
    run_op("divu_zero", 2'b11, 32'h1234, 32'd0);
    run_op("div_zero",  2'b10, 32'h8000_0007, 32'd0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start and MTLO while busy are both ignored
    exp = model(2'b01, 32'h0001_0003, 32'h0000_0100);
    drive_start(2'b01, 32'h0001_0003, 32'h0000_0100);
    lo_before = lo_o;
    repeat (4) @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; rs_data_i = 32'h55; rt_data_i = 32'h3;
    mtlo_i = 1'b1; wr_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    start_i = 1'b0; mtlo_i = 1'b0;
    check("busy.lo_kept", 64'(lo_o), 64'(lo_before));
    edges = 5;
    wait_done(edges);
    check("busy.lat", 64'(edges), 64'd33);
    check("busy.hilo", {hi_o, lo_o}, exp);
    @(negedge clk);

    mthi_i = 1'b1; wr_data_i = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi_i = 1'b0;
    check("mthi.idle", 64'(hi_o), 64'hA5A5_A5A5);
    mthi_i = 1'b1; mtlo_i = 1'b1; wr_data_i = 32'h1357_9BDF;
    @(negedge clk);
    mthi_i = 1'b0; mtlo_i = 1'b0;
    check("mthilo.both", {hi_o, lo_o}, 64'h1357_9BDF_1357_9BDF);

    // Start wins over a same-edge MTLO
    exp = model(2'b00, 32'd1000, 32'hFFFF_FF00);
    mtlo_i = 1'b1; wr_data_i = 32'hCAFE_F00D;
    drive_start(2'b00, 32'd1000, 32'hFFFF_FF00);
    mtlo_i = 1'b0;
    check("startlo.hi_kept", 64'(hi_o), 64'h1357_9BDF);
    edges = 0;
    wait_done(edges);
    check("startlo.hilo", {hi_o, lo_o}, exp);

    // Back-to-back start in the DONE cycle
    exp = model(2'b10, 32'hFFFF_0000, 32'd300);
    drive_start(2'b10, 32'hFFFF_0000, 32'd300);
    check("b2b.first_hold", {hi_o, lo_o}, model(2'b00, 32'd1000, 32'hFFFF_FF00));
    check("b2b.busy", {62'b0, busy_o, done_o}, 64'd2);
    edges = 0;
    wait_done(edges);
    check("b2b.lat", 64'(edges), 64'd33);
    check("b2b.hilo", {hi_o, lo_o}, exp);
    @(negedge clk);

    // Asynchronous reset between edges mid-CALC
    drive_start(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("arst.now", {31'b0, busy_o, hi_o, lo_o}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    check("arst.no_done", 64'(saw_done), 64'd0);
    check("arst.idle", {31'b0, busy_o, hi_o, lo_o}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFFF;
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op($sformatf("rnd%0d", i), op, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
